param_updown_counter: RTL



---
 rtl/param_updown_counter.sv | 98 +++++++++
 1 files changed

// File: rtl/param_updown_counter.sv
// Parametrised up/down counter with load, wrap/saturate, terminal-count pulse and sticky overflow.
// Optional step prescaler is built only when COUNTER_PRESCALE_EN is defined.
module param_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int MAX_COUNT = 15,
    parameter int PRESCALE  = 4
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             UpDown,
    input  logic             Saturate,
    input  logic             ClrOvf,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_COUNT);

    if (MAX_COUNT < 1 || MAX_COUNT > (2 ** WIDTH) - 1) begin : g_bad_max
        $error("param_updown_counter: MAX_COUNT out of range for WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $error("param_updown_counter: PRESCALE must be >= 1");
    end

    logic             step;
    logic             at_top;
    logic             at_bot;
    logic             boundary;
    logic [WIDTH-1:0] count_d;
    logic             tc_d;
    logic             ovf_d;

`ifdef COUNTER_PRESCALE_EN
    localparam int PW = (PRESCALE <= 1) ? 1 : $clog2(PRESCALE);
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    always_comb begin
        step  = Enable && (pre_q == PLAST);
        pre_d = pre_q;
        if (Load) begin
            pre_d = '0;
        end else if (Enable) begin
            pre_d = step ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign step = Enable;
`endif

    assign at_top   = (count == MAXV);
    assign at_bot   = (count == '0);
    assign boundary = step && !Load && (UpDown ? at_top : at_bot);

    always_comb begin
        count_d = count;
        if (Load) begin
            count_d = (LoadVal > MAXV) ? MAXV : LoadVal;
        end else if (step) begin
            if (UpDown) begin
                count_d = at_top ? (Saturate ? MAXV : '0) : count + WIDTH'(1);
            end else begin
                count_d = at_bot ? (Saturate ? '0 : MAXV) : count - WIDTH'(1);
            end
        end
        tc_d  = boundary;
        // a boundary event in the same cycle as ClrOvf keeps the flag set
        ovf_d = boundary || (ovf && !ClrOvf);
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= count_d;
            tc    <= tc_d;
            ovf   <= ovf_d;
        end
    end

endmodule
